frame_buffer_arbiter: RTL and testbench

//  Owns the single-port 1-bit framebuffer RAM (160x120 pixels, addr = {Y[6:0],X[7:0]}).

---
 rtl/frame_buffer_arbiter.sv | 175 +++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares a single-port 1-bit framebuffer RAM between VGA scan-out and a host writer
// Optional full-screen clear sequencer is built when FB_CLEAR_EN is defined.
module frame_buffer_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 120
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_vga_strobe,
    input  logic [ADDR_WIDTH-1:0] i_vga_addr,
    output logic                  o_vga_data,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic                  i_host_data,
    output logic                  o_host_ready,
    input  logic                  i_clear_req,
    input  logic                  i_clear_value,
    output logic                  o_clear_busy,
    output logic                  o_clear_done,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_we,
    output logic                  o_ram_wdata,
    input  logic                  i_ram_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int XW = 8;
    localparam int YW = ADDR_WIDTH - XW;

    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_data;
    logic [PW:0]           r_wp;
    logic [PW:0]           r_rp;
    logic                  r_rd_pending;
    logic                  r_vga_data;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_idle;
    logic                  w_clr_state;
    logic                  w_read;
    logic                  w_free;
    logic                  w_clr_wr;
    logic                  w_pop;
    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic                  w_head_data;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_data;

    assign w_empty     = r_wp == r_rp;
    assign w_full      = (r_wp - r_rp) == (PW+1)'(FIFO_DEPTH);
    assign w_head_addr = r_fifo_addr[r_rp[PW-1:0]];
    assign w_head_data = r_fifo_data[r_rp[PW-1:0]];

    // Slot selection: VGA read always wins, then clear write, then FIFO pop; nothing reaches the RAM in reset
    assign w_read   = !i_reset && i_vga_strobe;
    assign w_free   = !i_reset && !i_vga_strobe;
    assign w_clr_wr = w_free && w_clr_state;
    assign w_pop    = w_free && !w_clr_state && !w_empty;
    assign w_push   = i_host_we && o_host_ready;

    assign o_host_ready = !i_reset && !w_full && w_idle;
    assign o_vga_data   = r_vga_data;

    // RAM port driven combinationally from the slot type
    always_comb begin
        o_ram_addr  = w_read ? i_vga_addr : w_clr_wr ? w_clr_addr : w_pop ? w_head_addr : '0;
        o_ram_we    = w_clr_wr || w_pop;
        o_ram_wdata = w_clr_wr ? w_clr_data : w_pop ? w_head_data : 1'b0;
    end

    // Host write queue: in-order, a pushed entry becomes visible to the pop side next cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wp[PW-1:0]] <= i_host_addr;
                r_fifo_data[r_wp[PW-1:0]] <= i_host_data;
                r_wp                      <= r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
        end
    end

    // Scan-out pixel captured the cycle after a read slot, giving two cycles address-to-pixel
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_pending <= 1'b0;
            r_vga_data   <= 1'b0;
        end else begin
            r_rd_pending <= w_read;
            if (r_rd_pending)
                r_vga_data <= i_ram_rdata;
        end
    end

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_clear_value;
    logic          r_clear_busy;
    logic          r_clear_done;

    assign w_idle       = r_state == S_IDLE;
    assign w_clr_state  = r_state == S_CLEAR;
    assign w_clr_addr   = {r_y, r_x};
    assign w_clr_data   = r_clear_value;
    assign o_clear_busy = r_clear_busy;
    assign o_clear_done = r_clear_done;

    // Clear sequencer: drain queued host writes, then sweep every visible pixel raster-order
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_clear_value <= 1'b0;
            r_clear_busy  <= 1'b0;
            r_clear_done  <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_clear_req) begin
                        r_state       <= S_DRAIN;
                        r_clear_value <= i_clear_value;
                        r_x           <= '0;
                        r_y           <= '0;
                        r_clear_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_empty)
                        r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (w_clr_wr) begin
                        if (r_x == XW'(X_MAX-1)) begin
                            r_x <= '0;
                            if (r_y == YW'(Y_MAX-1)) begin
                                r_state      <= S_IDLE;
                                r_clear_busy <= 1'b0;
                                r_clear_done <= 1'b1;
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = i_clear_req ^ i_clear_value;
    assign w_idle         = 1'b1;
    assign w_clr_state    = 1'b0;
    assign w_clr_addr     = '0;
    assign w_clr_data     = 1'b0;
    assign o_clear_busy   = 1'b0;
    assign o_clear_done   = 1'b0;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: randomized bench for frame_buffer_arbiter against a queue-based slot model
module tb_frame_buffer_arbiter;
`ifdef FB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int NPIX = 160 * 120;

    typedef struct packed {
        logic [14:0] a;
        logic        d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_strobe;
    logic [14:0] vga_addr;
    logic        vga_data;
    logic        host_we;
    logic [14:0] host_addr;
    logic        host_data;
    logic        host_ready;
    logic        clear_req;
    logic        clear_value;
    logic        clear_busy;
    logic        clear_done;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic        ram_wdata;
    logic        ram_rdata;

    logic        pre_we;
    logic [14:0] pre_a;
    logic        pre_d;
    bit          mem [0:32767];

    int n_chk  = 0;
    int n_fail = 0;

    bit          mm [0:32767];
    wr_t         q[$];
    int          phase;
    int          k;
    bit          cv_m;
    bit          done_m;
    bit          d1v, d1d, d2v, d2d;
    bit          exp_vga;
    int          ndone;
    bit          last_acc;
    logic [14:0] pool [8];

    frame_buffer_arbiter dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_vga_strobe  (vga_strobe),
        .i_vga_addr    (vga_addr),
        .o_vga_data    (vga_data),
        .i_host_we     (host_we),
        .i_host_addr   (host_addr),
        .i_host_data   (host_data),
        .o_host_ready  (host_ready),
        .i_clear_req   (clear_req),
        .i_clear_value (clear_value),
        .o_clear_busy  (clear_busy),
        .o_clear_done  (clear_done),
        .o_ram_addr    (ram_addr),
        .o_ram_we      (ram_we),
        .o_ram_wdata   (ram_wdata),
        .i_ram_rdata   (ram_rdata)
    );

    always #10 clk = ~clk;

    // Synchronous single-port RAM, read data one cycle after the address
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle, advance the model
    task automatic step(input bit s, input logic [14:0] va, input bit we, input logic [14:0] ha,
                        input bit hd, input bit cr, input bit cv);
        bit          eready, ewe, ewd, popd, clrw, was_empty;
        logic [14:0] eaddr;
        int          ph;
        vga_strobe  = s;
        vga_addr    = va;
        host_we     = we;
        host_addr   = ha;
        host_data   = hd;
        clear_req   = cr;
        clear_value = cv;
        @(negedge clk);
        ph        = phase;
        was_empty = q.size() == 0;
        eready    = ph == 0 && q.size() < 4;
        clrw      = 1'b0;
        popd      = 1'b0;
        ewe       = 1'b0;
        ewd       = 1'b0;
        eaddr     = va;
        if (!s) begin
            if (ph == 2) begin
                clrw  = 1'b1;
                ewe   = 1'b1;
                ewd   = cv_m;
                eaddr = 15'(((k / 160) << 8) + (k % 160));
            end else if (!was_empty) begin
                popd  = 1'b1;
                ewe   = 1'b1;
                ewd   = q[0].d;
                eaddr = q[0].a;
            end
        end
        chk("host_ready", host_ready, eready);
        chk("ram_we", ram_we, ewe);
        if (s || ewe)
            chk("ram_addr", ram_addr, eaddr);
        if (ewe)
            chk("ram_wdata", ram_wdata, ewd);
        chk("clear_busy", clear_busy, ph != 0);
        chk("clear_done", clear_done, done_m);
        if (d2v)
            exp_vga = d2d;
        chk("vga_data", vga_data, exp_vga);
        d2v = d1v;
        d2d = d1d;
        d1v = s;
        d1d = mm[va];
        if (clear_done)
            ndone++;
        done_m = 1'b0;
        if (popd) begin
            mm[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (clrw) begin
            mm[eaddr] = cv_m;
            k++;
            if (k == NPIX) begin
                phase  = 0;
                done_m = 1'b1;
            end
        end
        if (ph == 1 && was_empty) begin
            phase = 2;
            k     = 0;
        end
        last_acc = we && eready;
        if (last_acc)
            q.push_back('{a: ha, d: hd});
        if (ph == 0 && CLR && cr) begin
            phase = 1;
            cv_m  = cv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        vga_strobe  = 1'($urandom_range(0, 1));
        vga_addr    = 15'h1234;
        host_we     = 1'b1;
        clear_req   = 1'b1;
        @(negedge clk);
        chk("rst_ready", host_ready, 0);
        chk("rst_we", ram_we, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready2", host_ready, 0);
        chk("rst_we2", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_vga", vga_data, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        q.delete();
        phase   = 0;
        done_m  = 1'b0;
        d1v     = 1'b0;
        d2v     = 1'b0;
        exp_vga = 1'b0;
        host_we   = 1'b0;
        clear_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit          hw;
        logic [14:0] ha;
        bit          hd;
        int          acc;
        wr_t         items [5];
        pool = '{15'h0005, 15'h0105, 15'h1234, 15'h779F, 15'h0000, 15'h009F, 15'h0100, 15'h2AAA};
        reset = 1'b1;
        vga_strobe = 1'b0;
        vga_addr = '0;
        host_we = 1'b0;
        host_addr = '0;
        host_data = 1'b0;
        clear_req = 1'b0;
        clear_value = 1'b0;
        pre_we = 1'b0;
        pre_a = '0;
        pre_d = 1'b0;
        phase = 0;
        k = 0;
        ndone = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            pre_we = 1'b1;
            pre_a  = pool[i];
            pre_d  = (pool[i] == 15'h1234) ? 1'b1 : 1'($urandom_range(0, 1));
            mm[pre_a] = pre_d;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        do_reset();

        // Alternating scan-out reads of a pixel holding 1
        for (int i = 0; i < 8; i++)
            step(i % 2 == 0, 15'h1234, 0, '0, 0, 0, 0);
        chk("t1_vga_one", vga_data, 1);

        // Back-to-back host writes land in free slots, in order
        step(0, 15'h0000, 1, 15'h0005, 1, 0, 0);
        step(1, 15'h0005, 1, 15'h0105, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(i % 2 == 1, (i < 3) ? 15'h0005 : 15'h0105, 0, '0, 0, 0, 0);
        chk("t2_vga_last", vga_data, 0);

        // Strobe held high: queue fills at 4, fifth write waits
        for (int i = 0; i < 5; i++)
            items[i] = '{a: pool[$urandom_range(0, 7)], d: 1'($urandom_range(0, 1))};
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, pool[$urandom_range(0, 7)], acc < 5, items[acc < 5 ? acc : 4].a, items[acc < 5 ? acc : 4].d, 0, 0);
            if (last_acc)
                acc++;
        end
        chk("t3_accepted_while_strobe", acc, 4);
        for (int i = 0; i < 40 && (acc < 5 || q.size() != 0); i++) begin
            step(i % 2 == 1, pool[$urandom_range(0, 7)], acc < 5, items[4].a, items[4].d, 0, 0);
            if (last_acc)
                acc++;
        end
        chk("t3_all_drained", q.size(), 0);

        // Random traffic, with a mid-run reset; clear pulses exercised only where clearing is absent
        hw = 1'b0;
        ha = '0;
        hd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500)
                do_reset();
            if (!hw) begin
                hw = $urandom_range(0, 9) < 6;
                ha = pool[$urandom_range(0, 7)];
                hd = 1'($urandom_range(0, 1));
            end
            step(($urandom_range(0, 3) != 0) ? (i % 2 == 0) : 1'($urandom_range(0, 1)),
                 pool[$urandom_range(0, 7)], hw, ha, hd,
                 CLR ? 1'b0 : ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
            if (last_acc)
                hw = 1'b0;
        end
        chk("t6_no_done_seen", ndone, 0);

`ifdef FB_CLEAR_EN
        // Full clear to 1 with two writes queued ahead of it
        for (int i = 0; i < 10; i++)
            step(i % 2 == 1, '0, 0, '0, 0, 0, 0);
        ndone = 0;
        step(1, 15'h0000, 1, 15'h0105, 0, 0, 0);
        step(1, 15'h0000, 1, 15'h779F, 0, 0, 0);
        step(1, 15'h0000, 0, '0, 0, 1, 1);
        begin
            int n = 0;
            while ((phase != 0 || done_m) && n < 40000) begin
                step(n % 2 == 1, pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), pool[0], 0, 0, 0);
                n++;
            end
            chk("t4_timeout", n < 40000, 1);
        end
        chk("t4_done_pulses", ndone, 1);
        chk("t4_last_pixel", mem[15'h779F], 1);
        chk("t4_first_pixel", mem[15'h0000], 1);
        chk("t4_row1_pixel", mem[15'h0105], 1);

        // Reset partway through a clear aborts it without a done pulse
        ndone = 0;
        step(0, '0, 0, '0, 0, 1, 0);
        begin
            int n = 0;
            while (!(phase == 2 && k == 1000) && n < 5000) begin
                step(n % 2 == 1, '0, 0, '0, 0, 0, 0);
                n++;
            end
            chk("t5_timeout", n < 5000, 1);
        end
        do_reset();
        step(0, '0, 1, 15'h2AAA, 1, 0, 0);
        chk("t5_idle_busy", clear_busy, 0);
        step(1, '0, 0, '0, 0, 0, 0);
        step(0, '0, 0, '0, 0, 0, 0);
        chk("t5_no_done", ndone, 0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
